// File: rtl/pwm_capture_if.sv
// Signal bundle between the PWM capture block and whatever drives its input / consumes results.
// The capture block uses the slave side; the driving environment uses the master side.
interface pwm_capture_if #(
    parameter int CW = 26
);
    logic          pwm_in;
    logic [CW-1:0] period_out;
    logic [CW-1:0] high_out;
    logic [6:0]    duty_pct;
    logic          valid;
    logic          stuck;
    logic          overrun;
    logic [7:0]    leds;

    modport master (
        output pwm_in,
        input  period_out, high_out, duty_pct, valid, stuck, overrun, leds
    );

    modport slave (
        input  pwm_in,
        output period_out, high_out, duty_pct, valid, stuck, overrun, leds
    );
endinterface

// File: rtl/pwm_capture.sv
// PWM receiver: measures period and high time of pwm_in, derives duty cycle in percent with a
// restoring divider (one quotient bit per clock) and drives an 8-LED bar graph.
module pwm_capture #(
    parameter int CLK_FREQ       = 25_000_000,
    parameter int CW             = 26,
    parameter int TIMEOUT_CYCLES = CLK_FREQ
) (
    input  logic         clk,
    input  logic         rst,
    pwm_capture_if.slave bus,
    output logic [1:0]   dbg_state_o
);
    localparam int NUM_W = CW + 7;
    localparam int IW    = $clog2(NUM_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state_q;
    logic             s1_q, s_q, sd_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    h_lat_q;
    logic [CW-1:0]    den_q;
    logic [CW-1:0]    hold_h_q;
    logic [CW-1:0]    rem_q;
    logic [NUM_W-1:0] num_q;
    logic [IW-1:0]    iter_q;
    logic             busy_q;
    logic [CW-1:0]    period_q;
    logic [CW-1:0]    high_q;
    logic [6:0]       duty_q;
    logic             valid_q;
    logic             stuck_q;
    logic             overrun_q;
    logic [7:0]       leds_q;

    logic             rise, fall, timeout;
    logic [CW:0]      rem_sh;
    logic [CW-1:0]    rem_d;
    logic [NUM_W-1:0] num_d;
    logic             q_bit;
    logic [NUM_W-1:0] num_init;

    assign rise     = s_q & ~sd_q;
    assign fall     = ~s_q & sd_q;
    // An edge arriving on the timeout cycle wins over the timeout.
    assign timeout  = (cnt_q == CW'(TIMEOUT_CYCLES)) && !rise && !fall;
    assign num_init = NUM_W'(h_lat_q) * NUM_W'(100);

    // One restoring step: the quotient bits shift into the bottom of num_q as the numerator leaves.
    always_comb begin
        rem_sh = {rem_q, num_q[NUM_W-1]};
        q_bit  = (rem_sh >= {1'b0, den_q});
        rem_d  = q_bit ? CW'(rem_sh - {1'b0, den_q}) : rem_sh[CW-1:0];
        num_d  = {num_q[NUM_W-2:0], q_bit};
    end

    function automatic logic [7:0] bar_of(input logic [6:0] d);
        bar_of[0] = (d >= 7'd12);
        bar_of[1] = (d >= 7'd25);
        bar_of[2] = (d >= 7'd37);
        bar_of[3] = (d >= 7'd50);
        bar_of[4] = (d >= 7'd62);
        bar_of[5] = (d >= 7'd75);
        bar_of[6] = (d >= 7'd87);
        bar_of[7] = (d >= 7'd100);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            s1_q      <= 1'b0;
            s_q       <= 1'b0;
            sd_q      <= 1'b0;
            cnt_q     <= '0;
            h_lat_q   <= '0;
            den_q     <= '0;
            hold_h_q  <= '0;
            rem_q     <= '0;
            num_q     <= '0;
            iter_q    <= '0;
            busy_q    <= 1'b0;
            period_q  <= '0;
            high_q    <= '0;
            duty_q    <= '0;
            valid_q   <= 1'b0;
            stuck_q   <= 1'b0;
            overrun_q <= 1'b0;
            leds_q    <= '0;
        end else begin
            s1_q    <= bus.pwm_in;
            s_q     <= s1_q;
            sd_q    <= s_q;
            valid_q <= 1'b0;

            if (busy_q) begin
                rem_q  <= rem_d;
                num_q  <= num_d;
                iter_q <= iter_q - IW'(1);
                if (iter_q == IW'(1)) begin
                    busy_q   <= 1'b0;
                    valid_q  <= 1'b1;
                    period_q <= den_q;
                    high_q   <= hold_h_q;
                    duty_q   <= num_d[6:0];
                    leds_q   <= bar_of(num_d[6:0]);
                end
            end

            if (timeout) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                busy_q  <= 1'b0;
                stuck_q <= 1'b1;
                valid_q <= !stuck_q;
                if (!stuck_q) begin
                    period_q <= '0;
                    high_q   <= '0;
                    duty_q   <= s_q ? 7'd100 : 7'd0;
                    leds_q   <= s_q ? 8'hFF : 8'h00;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rise) begin
                            state_q <= HIGH;
                            cnt_q   <= CW'(1);
                            stuck_q <= 1'b0;
                        end else if (fall) begin
                            cnt_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            h_lat_q <= cnt_q;
                            state_q <= LOW;
                        end
                        cnt_q <= rise ? CW'(1) : cnt_q + CW'(1);
                    end
                    LOW: begin
                        if (rise) begin
                            state_q <= HIGH;
                            cnt_q   <= CW'(1);
                            if (busy_q) begin
                                overrun_q <= 1'b1;
                            end else begin
                                num_q    <= num_init;
                                den_q    <= cnt_q;
                                hold_h_q <= h_lat_q;
                                rem_q    <= '0;
                                iter_q   <= IW'(NUM_W);
                                busy_q   <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.period_out = period_q;
    assign bus.high_out   = high_q;
    assign bus.duty_pct   = duty_q;
    assign bus.valid      = valid_q;
    assign bus.stuck      = stuck_q;
    assign bus.overrun    = overrun_q;
    assign bus.leds       = leds_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: an edge-level model predicts every result and its cycle,
// a negedge monitor pops and compares them when valid pulses.
module tb_pwm_capture;
    localparam int CW = 26;
    localparam int TO = 1000;
    localparam int W  = CW + CW + 7 + 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    logic [W-1:0] exp_q[$];
    int           exp_c_q[$];

    // Edge-level reference model (cycle stamps are negedge counts at which pwm_in was driven).
    int   m_state;
    int   m_rise_k, m_fall_k, m_busy_end;
    logic m_overrun;
    logic cur;
    int   thr[8] = '{12, 25, 37, 50, 62, 75, 87, 100};

    pwm_capture_if #(.CW(CW)) bus ();

    pwm_capture #(.CW(CW), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push_result(input int p, input int h, input int k);
        int         duty;
        logic [7:0] l;
        duty = (h * 100) / p;
        for (int i = 0; i < 8; i++) l[i] = (duty >= thr[i]);
        exp_q.push_back({CW'(p), CW'(h), 7'(duty), l});
        exp_c_q.push_back(k + 36);
    endtask

    task automatic model_rise(input int k);
        if (m_state == 2) begin
            if (k >= m_busy_end) begin
                push_result(k - m_rise_k, m_fall_k - m_rise_k, k);
                m_busy_end = k + 34;
            end else begin
                m_overrun = 1'b1;
            end
        end
        m_state  = 1;
        m_rise_k = k;
    endtask

    task automatic model_fall(input int k);
        if (m_state == 1) begin
            m_state  = 2;
            m_fall_k = k;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_c_q.delete();
        m_state    = 0;
        m_busy_end = 0;
        m_overrun  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_pwm(input logic v);
        @(negedge clk);
        if (v !== cur) begin
            if (v) model_rise(cyc);
            else   model_fall(cyc);
        end
        bus.pwm_in = v;
        cur = v;
    endtask

    task automatic pwm_wave(input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            set_pwm(1'b1);
            idle(h - 1);
            set_pwm(1'b0);
            idle(l - 1);
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk(tag, {bus.period_out, bus.high_out, bus.duty_pct, bus.valid, bus.stuck,
                  bus.overrun, bus.leds, dbg_state}, '0);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && bus.valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", bus.valid, 1'b0);
            end else begin
                logic [W-1:0] e;
                int           c;
                e = exp_q.pop_front();
                c = exp_c_q.pop_front();
                chk("valid_cycle", cyc, c);
                chk("result", {bus.period_out, bus.high_out, bus.duty_pct, bus.leds}, e);
            end
        end
    end

    initial begin
        int k;
        rst        = 1'b1;
        bus.pwm_in = 1'b0;
        cur        = 1'b0;
        model_reset();

        // reset with pwm_in toggling
        repeat (3) begin
            @(negedge clk);
            bus.pwm_in = ~bus.pwm_in;
            chk("reset_no_valid", bus.valid, 1'b0);
        end
        @(negedge clk);
        bus.pwm_in = 1'b0;
        idle(2);
        chk_cleared("reset_state");
        rst = 1'b0;
        idle(3);
        chk_cleared("after_reset");

        // 30/70 steady
        pwm_wave(30, 70, 5);
        chk("overrun_30_70", bus.overrun, m_overrun);

        // extreme duties
        pwm_wave(1, 149, 3);
        pwm_wave(149, 1, 3);
        chk("overrun_extreme", bus.overrun, m_overrun);

        // period 30 < min measurable: alternate periods dropped
        pwm_wave(20, 10, 8);
        chk("overrun_set", bus.overrun, 1'b1);

        // stuck high
        set_pwm(1'b1);
        k = cyc;
        exp_q.push_back({CW'(0), CW'(0), 7'd100, 8'hFF});
        exp_c_q.push_back(k + TO + 3);
        m_state = 0;
        idle(1010);
        chk("stuck_set", bus.stuck, 1'b1);
        chk("stuck_idle", dbg_state, 2'd0);
        set_pwm(1'b0);
        idle(49);
        chk("stuck_holds", bus.stuck, 1'b1);
        set_pwm(1'b1);
        idle(4);
        chk("stuck_clear", bus.stuck, 1'b0);
        idle(45);
        set_pwm(1'b0);
        idle(49);
        pwm_wave(50, 50, 3);
        chk("overrun_sticky", bus.overrun, 1'b1);

        // reset in the middle of a division
        pwm_wave(40, 60, 2);
        set_pwm(1'b1);
        idle(13);
        rst        = 1'b1;
        bus.pwm_in = 1'b0;
        cur        = 1'b0;
        model_reset();
        idle(3);
        chk_cleared("mid_div_reset");
        rst = 1'b0;
        idle(40);
        chk_cleared("after_mid_div_reset");
        pwm_wave(25, 75, 4);

        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("overrun_final", bus.overrun, m_overrun);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
